instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/rv32i_pkg.sv | 23 ++
 rtl/instr_fetch_if.sv | 28 ++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/instr_fetch.sv | 124 ++++++++++++
 tb/tb_instr_fetch.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch types: word size, buffer entry layout and fetch FSM states.
package rv32i_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        FAULT
    } fetch_state_t;

    // Sequential fetch address; wraps naturally at the top of the address space.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch unit bus: instruction memory port, redirect input and instruction output.
interface instr_fetch_if;
    import rv32i_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;
    logic            fetch_fault;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_fault,
        input  imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_fault,
        output imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer: circular FIFO of fetch entries with synchronous clear.
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [3:0]   count,
    output logic         empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [3:0]     count_q;
    logic           do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_pop  = pop && (count_q != 4'd0);
    // A full buffer still takes a push when the head leaves in the same cycle.
    assign do_push = push && !clr && ((count_q != 4'(DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + 4'(do_push) - 4'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == 4'd0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC sequencing, request credits and redirect flush.
// Optional FETCH_ALIGN_CHECK_EN traps misaligned redirect targets into a sticky fault.
module instr_fetch
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     DEPTH    = 2
) (
    input logic            clk,
    input logic            rst,
    instr_fetch_if.master  bus
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [3:0]      inflight_q, inflight_d;
    logic [3:0]      discard_q, discard_d;

    logic            fifo_clr, fifo_push, fifo_pop, fifo_empty;
    logic [3:0]      fifo_count;
    fetch_entry_t    fifo_head, fifo_in;
    logic            transfer, credit_ok, misaligned;
    logic [XLEN-1:0] target_pc;

`ifdef FETCH_ALIGN_CHECK_EN
    assign target_pc  = bus.redirect_pc;
    assign misaligned = |bus.redirect_pc[1:0];
`else
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^bus.redirect_pc[1:0];
    assign target_pc  = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign misaligned = 1'b0;
`endif

    // Every outstanding request owns a buffer slot, so responses never overflow.
    assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_count}) < 5'(DEPTH);
    assign bus.imem_req  = !rst && (state_q == RUN) && !bus.redirect_valid && credit_ok;
    assign bus.imem_addr = fetch_pc_q;
    assign transfer      = bus.imem_req && bus.imem_ready;

    assign fifo_in  = '{pc: resp_pc_q, instr: bus.imem_rdata};
    assign fifo_pop = bus.instr_valid && bus.instr_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        discard_d  = discard_q;
        inflight_d = inflight_q + 4'(transfer) - 4'(bus.imem_rvalid);
        fifo_clr   = 1'b0;
        fifo_push  = 1'b0;
        if (bus.redirect_valid) begin
            fifo_clr   = 1'b1;
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
            discard_d  = inflight_q - 4'(bus.imem_rvalid);
            if (misaligned || (state_q == FAULT)) begin
                state_d = FAULT;
            end else begin
                state_d = (discard_d != 4'd0) ? FLUSH : RUN;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (transfer) fetch_pc_d = next_pc(fetch_pc_q);
                    if (bus.imem_rvalid) begin
                        fifo_push = 1'b1;
                        resp_pc_d = next_pc(resp_pc_q);
                    end
                end
                FLUSH: begin
                    if (bus.imem_rvalid) begin
                        discard_d = discard_q - 4'd1;
                        if (discard_q == 4'd1) state_d = RUN;
                    end
                end
                FAULT: ;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (fifo_clr),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign bus.instr_valid = !fifo_empty;
    assign bus.instr       = fifo_head.instr;
    assign bus.instr_pc    = fifo_head.pc;

`ifdef FETCH_ALIGN_CHECK_EN
    assign bus.fetch_fault = (state_q == FAULT);
`else
    assign bus.fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: in-order memory with variable latency, queue-based reference model.
module tb_instr_fetch;
    import rv32i_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    instr_fetch_if bus();

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // stimulus knobs
    logic        st_rst, st_ready, st_iready, st_redir;
    logic [31:0] st_rpc;
    int unsigned lat;
    int unsigned cyc;

    // memory: in-order queue of accepted addresses with due cycle
    logic [31:0] mq_addr[$];
    int unsigned mq_due[$];

    // reference model
    logic [31:0]  m_fetch, m_resp;
    int           m_inflight, m_discard;
    bit           m_fault;
    fetch_entry_t m_buf[$];

    logic [31:0] deliv[$];
    int          n_xfer, n_req;
    logic        last_req, last_fault;
    logic [31:0] last_addr;

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle();
        logic        rv;
        logic [31:0] rd, eff;
        logic        exp_req, s_req;
        logic [31:0] s_addr;
        bit          mis;
        @(negedge clk);
        rst                = st_rst;
        bus.imem_ready     = st_ready;
        bus.instr_ready    = st_iready;
        bus.redirect_valid = st_redir && !st_rst;
        bus.redirect_pc    = st_rpc;
        rv = !st_rst && (mq_addr.size() > 0) && (mq_due[0] <= cyc);
        rd = rv ? mem_word(mq_addr[0]) : 32'h0;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rd;
        #1;
        if (st_rst) begin
            exp_req = 1'b0;
            chk("rst_imem_req", bus.imem_req, 0);
            chk("rst_instr_valid", bus.instr_valid, 0);
            chk("rst_fetch_fault", bus.fetch_fault, 0);
        end else begin
            exp_req = !m_fault && (m_discard == 0) && !bus.redirect_valid &&
                      ((m_inflight + m_buf.size()) < DEPTH);
            chk("imem_req", bus.imem_req, exp_req);
            if (exp_req) chk("imem_addr", bus.imem_addr, m_fetch);
            chk("instr_valid", bus.instr_valid, m_buf.size() != 0);
            if (m_buf.size() != 0) begin
                chk("instr_pc", bus.instr_pc, m_buf[0].pc);
                chk("instr", bus.instr, m_buf[0].instr);
            end
            chk("fetch_fault", bus.fetch_fault, m_fault);
        end
        s_req      = bus.imem_req;
        s_addr     = bus.imem_addr;
        last_req   = s_req;
        last_addr  = s_addr;
        last_fault = bus.fetch_fault;
        if (s_req) n_req++;
        if (!st_rst && bus.instr_valid && st_iready) deliv.push_back(bus.instr_pc);
        @(posedge clk);
        if (st_rst) begin
            m_fetch = 32'h0; m_resp = 32'h0; m_inflight = 0; m_discard = 0; m_fault = 0;
            m_buf.delete();
            mq_addr.delete(); mq_due.delete();
        end else begin
            if (bus.redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
                eff = st_rpc;
                mis = (st_rpc[1:0] != 2'b00);
`else
                eff = st_rpc & 32'hFFFF_FFFC;
                mis = 1'b0;
`endif
                m_buf.delete();
                m_fetch = eff;
                m_resp  = eff;
                if (rv) m_inflight--;
                m_discard = m_inflight;
                if (mis) m_fault = 1;
            end else begin
                if (m_buf.size() != 0 && st_iready) void'(m_buf.pop_front());
                if (exp_req && st_ready) begin
                    m_fetch += 32'd4;
                    m_inflight++;
                end
                if (rv) begin
                    m_inflight--;
                    if (m_discard > 0) m_discard--;
                    else if (!m_fault) begin
                        m_buf.push_back('{pc: m_resp, instr: rd});
                        m_resp += 32'd4;
                    end
                end
            end
            if (rv) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (s_req && st_ready) begin
                mq_addr.push_back(s_addr);
                mq_due.push_back(cyc + lat);
                n_xfer++;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        st_rst = 1; st_redir = 0; st_ready = 1; st_iready = 1; lat = 1;
        cycle();
        cycle();
        st_rst = 0;
        deliv.delete();
        n_xfer = 0;
        n_req  = 0;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        st_redir = 1; st_rpc = pc;
        cycle();
        st_redir = 0;
    endtask

    initial begin
        int bad;
        cyc = 0; st_rpc = 32'h0;
        bus.imem_ready = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
        bus.redirect_valid = 0; bus.redirect_pc = 0; bus.instr_ready = 0;

        // Straight-line fetch with single-cycle memory
        do_reset();
        cycle();
        chk("first_req", last_req, 1);
        chk("first_addr", last_addr, 32'h0);
        repeat (11) cycle();
        chk("seq_count", deliv.size() >= 3, 1);
        if (deliv.size() >= 3) begin
            chk("seq_pc0", deliv[0], 32'h0);
            chk("seq_pc1", deliv[1], 32'h4);
            chk("seq_pc2", deliv[2], 32'h8);
        end

        // Backpressure: credits cap transfers at DEPTH
        do_reset();
        st_iready = 0;
        repeat (10) cycle();
        chk("bp_xfers", n_xfer, 2);
        chk("bp_req_off", last_req, 0);
        st_iready = 1;
        repeat (10) cycle();
        chk("bp_count", deliv.size() >= 3, 1);
        if (deliv.size() >= 3) begin
            chk("bp_pc0", deliv[0], 32'h0);
            chk("bp_pc1", deliv[1], 32'h4);
            chk("bp_pc2", deliv[2], 32'h8);
        end

        // Redirect with two requests in flight
        do_reset();
        lat = 6;
        repeat (3) cycle();
        chk("fl_xfers", n_xfer, 2);
        redirect_to(32'h100);
        lat = 1;
        repeat (20) cycle();
        bad = 0;
        foreach (deliv[i]) if (deliv[i] == 32'h0 || deliv[i] == 32'h4) bad++;
        chk("fl_stale", bad, 0);
        chk("fl_count", deliv.size() >= 1, 1);
        if (deliv.size() >= 1) chk("fl_pc0", deliv[0], 32'h100);

        // Second redirect while one stale response is still pending
        do_reset();
        lat = 4; cycle();
        lat = 9; cycle();
        cycle();
        redirect_to(32'h100);
        for (int i = 0; i < 20 && mq_addr.size() != 1; i++) cycle();
        chk("rr_pending", mq_addr.size(), 1);
        redirect_to(32'h200);
        lat = 1;
        repeat (25) cycle();
        bad = 0;
        foreach (deliv[i]) if (deliv[i] == 32'h4 || deliv[i] == 32'h100) bad++;
        chk("rr_stale", bad, 0);
        chk("rr_count", deliv.size() >= 1, 1);
        if (deliv.size() >= 1) chk("rr_pc0", deliv[0], 32'h200);

        // Address wrap at top of memory
        do_reset();
        repeat (2) cycle();
        redirect_to(32'hFFFF_FFFC);
        deliv.delete();
        repeat (10) cycle();
        chk("wr_count", deliv.size() >= 2, 1);
        if (deliv.size() >= 2) begin
            chk("wr_pc0", deliv[0], 32'hFFFF_FFFC);
            chk("wr_pc1", deliv[1], 32'h0000_0000);
        end

        // Misaligned redirect target
        do_reset();
        repeat (2) cycle();
        redirect_to(32'h102);
        deliv.delete();
`ifdef FETCH_ALIGN_CHECK_EN
        n_req = 0;
        cycle();
        chk("al_fault", last_fault, 1);
        repeat (10) cycle();
        chk("al_no_req", n_req, 0);
        chk("al_sticky", last_fault, 1);
`else
        repeat (10) cycle();
        chk("al_fault", last_fault, 0);
        chk("al_count", deliv.size() >= 1, 1);
        if (deliv.size() >= 1) chk("al_pc0", deliv[0], 32'h100);
`endif

        // Randomized traffic against the model
        do_reset();
        repeat (4000) begin
            st_ready  = ($urandom_range(0, 3) != 0);
            st_iready = ($urandom_range(0, 2) != 0);
            lat       = $urandom_range(1, 4);
            st_redir  = ($urandom_range(0, 19) == 0);
            st_rpc    = $urandom;
            if ($urandom_range(0, 3) != 0) st_rpc[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) st_rpc[31:4] = 28'hFFF_FFFF;
            st_rst    = ($urandom_range(0, 249) == 0);
            cycle();
        end
        st_rst = 0; st_redir = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
